// File: rtl/dispatch_buffer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dispatch_buffer_pkg: shared constants for the dispatch queue. Rev 1.0
// ---------------------------------------------------------------------------
package dispatch_buffer_pkg;

  localparam int DEF_DEPTH     = 4;
  localparam int DEF_NUM_UNITS = 5;
  localparam int DEF_NUM_WB    = 2;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_TAG_W     = 16;
  localparam int DEF_PAYLOAD_W = 64;

  localparam int UNIT_ALU    = 0;
  localparam int UNIT_FPU    = 1;
  localparam int UNIT_BRANCH = 2;
  localparam int UNIT_MEMORY = 3;
  localparam int UNIT_UART   = 4;

  // Queue pointers carry one extra wrap bit above the address.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dispatch_buffer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dispatch_buffer_if: decode / writeback / issue signals of the dispatch stage. Rev 1.0
// ---------------------------------------------------------------------------
interface dispatch_buffer_if
  import dispatch_buffer_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int NUM_UNITS = DEF_NUM_UNITS,
  parameter int NUM_WB    = DEF_NUM_WB,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TAG_W     = DEF_TAG_W,
  parameter int PAYLOAD_W = DEF_PAYLOAD_W,
  parameter int UNIT_W    = $clog2(NUM_UNITS)
);

  logic                        flash;
  logic                        in_en;
  logic                        in_reject;
  logic [UNIT_W-1:0]           in_unit;
  logic [PAYLOAD_W-1:0]        in_payload;
  logic [1:0]                  in_src_valid;
  logic [2*DATA_W-1:0]         in_src;
  logic [NUM_WB-1:0]           wb_en;
  logic [NUM_WB*TAG_W-1:0]     wb_tag;
  logic [NUM_WB*DATA_W-1:0]    wb_data;
  logic [NUM_UNITS-1:0]        out_en;
  logic [NUM_UNITS-1:0]        out_reject;
  logic [PAYLOAD_W-1:0]        out_payload;
  logic [1:0]                  out_src_valid;
  logic [2*DATA_W-1:0]         out_src;
  logic [$clog2(DEPTH):0]      count;

  modport master (
    output flash, in_en, in_unit, in_payload, in_src_valid, in_src,
    output wb_en, wb_tag, wb_data, out_reject,
    input  in_reject, out_en, out_payload, out_src_valid, out_src, count
  );

  modport slave (
    input  flash, in_en, in_unit, in_payload, in_src_valid, in_src,
    input  wb_en, wb_tag, wb_data, out_reject,
    output in_reject, out_en, out_payload, out_src_valid, out_src, count
  );

endinterface
`default_nettype wire

// File: rtl/dispatch_buffer_operand_wakeup.sv
`default_nettype none
// ---------------------------------------------------------------------------
// operand_wakeup: resolves one pending operand against the completion buses. Rev 1.0
// ---------------------------------------------------------------------------
module operand_wakeup #(
  parameter int NUM_WB = 2,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 16
) (
  input  wire logic                     i_valid,
  input  wire logic [DATA_W-1:0]        i_content,
  input  wire logic [NUM_WB-1:0]        i_wb_en,
  input  wire logic [NUM_WB*TAG_W-1:0]  i_wb_tag,
  input  wire logic [NUM_WB*DATA_W-1:0] i_wb_data,
  output logic                          o_valid,
  output logic [DATA_W-1:0]             o_content
);

  // Scan from the highest bus down so the lowest matching index is applied last.
  always_comb begin
    o_valid   = i_valid;
    o_content = i_content;
    if (!i_valid) begin
      for (int i = NUM_WB - 1; i >= 0; i--) begin
        if (i_wb_en[i] && (i_wb_tag[i*TAG_W +: TAG_W] == i_content[TAG_W-1:0])) begin
          o_valid   = 1'b1;
          o_content = i_wb_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dispatch_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dispatch_buffer: in-order issue queue with operand wakeup and head bypass. Rev 1.0
// ---------------------------------------------------------------------------
module dispatch_buffer
  import dispatch_buffer_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int NUM_UNITS = DEF_NUM_UNITS,
  parameter int NUM_WB    = DEF_NUM_WB,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TAG_W     = DEF_TAG_W,
  parameter int PAYLOAD_W = DEF_PAYLOAD_W,
  parameter int UNIT_W    = $clog2(NUM_UNITS)
) (
  input wire logic         clock,
  input wire logic         reset,
  dispatch_buffer_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ptr_width(DEPTH);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] content;
  } source_t;

  typedef struct packed {
    logic [UNIT_W-1:0]    unit;
    logic [PAYLOAD_W-1:0] payload;
    source_t [1:0]        src;
  } entry_t;

  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [PTR_W-1:0]     r_count;
  logic [DEPTH-1:0]     r_vld;

  logic [ADDR_W-1:0]    w_head_addr;
  logic [ADDR_W-1:0]    w_tail_addr;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_active;
  logic                 w_enq;
  logic                 w_deq;
  logic                 w_head_rej;
  logic [NUM_UNITS-1:0] w_out_en;
  logic [UNIT_W-1:0]    w_unit_arr [DEPTH];
  logic [PAYLOAD_W-1:0] w_pl_arr   [DEPTH];
  source_t              w_woke     [2][DEPTH];
  source_t              w_in_woke  [2];

  assign w_head_addr = r_head[ADDR_W-1:0];
  assign w_tail_addr = r_tail[ADDR_W-1:0];
  assign w_empty     = (r_head == r_tail);
  assign w_full      = (w_head_addr == w_tail_addr) && (r_head[ADDR_W] != r_tail[ADDR_W]);

  // in_reject is purely registered state; a dequeue this cycle gives no credit.
  assign w_enq    = bus.in_en && !w_full && !bus.flash;
  assign w_active = !w_empty && !bus.flash;

  // An out-of-range unit selects no channel, so it sees no reject and drains.
  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_issue
    assign w_out_en[u] = w_active && (w_unit_arr[w_head_addr] == UNIT_W'(u));
  end

  assign w_head_rej = |(w_out_en & bus.out_reject);
  assign w_deq      = w_active && !w_head_rej;

  // Incoming operands are woken before being written into the queue.
  for (genvar s = 0; s < 2; s++) begin : g_in
    logic              w_v;
    logic [DATA_W-1:0] w_d;

    operand_wakeup #(
      .NUM_WB (NUM_WB),
      .DATA_W (DATA_W),
      .TAG_W  (TAG_W)
    ) u_wake (
      .i_valid   (bus.in_src_valid[s]),
      .i_content (bus.in_src[s*DATA_W +: DATA_W]),
      .i_wb_en   (bus.wb_en),
      .i_wb_tag  (bus.wb_tag),
      .i_wb_data (bus.wb_data),
      .o_valid   (w_v),
      .o_content (w_d)
    );

    assign w_in_woke[s] = {w_v, w_d};
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    entry_t r_ent;

    for (genvar s = 0; s < 2; s++) begin : g_src
      logic              w_v;
      logic [DATA_W-1:0] w_d;

      operand_wakeup #(
        .NUM_WB (NUM_WB),
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W)
      ) u_wake (
        .i_valid   (r_ent.src[s].valid),
        .i_content (r_ent.src[s].content),
        .i_wb_en   (bus.wb_en),
        .i_wb_tag  (bus.wb_tag),
        .i_wb_data (bus.wb_data),
        .o_valid   (w_v),
        .o_content (w_d)
      );

      assign w_woke[s][e] = {w_v, w_d};
    end

    // Stored operands absorb completions every cycle, stalled head included.
    always_ff @(posedge clock) begin
      if (w_enq && (w_tail_addr == ADDR_W'(e))) begin
        r_ent.unit    <= bus.in_unit;
        r_ent.payload <= bus.in_payload;
        r_ent.src[0]  <= w_in_woke[0];
        r_ent.src[1]  <= w_in_woke[1];
      end else if (r_vld[e]) begin
        r_ent.src[0]  <= w_woke[0][e];
        r_ent.src[1]  <= w_woke[1][e];
      end
    end

    assign w_unit_arr[e] = r_ent.unit;
    assign w_pl_arr[e]   = r_ent.payload;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else if (bus.flash) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      if (w_enq) begin
        r_tail             <= r_tail + PTR_W'(1);
        r_vld[w_tail_addr] <= 1'b1;
      end
      if (w_deq) begin
        r_head             <= r_head + PTR_W'(1);
        r_vld[w_head_addr] <= 1'b0;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + PTR_W'(1);
        2'b01:   r_count <= r_count - PTR_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  for (genvar s = 0; s < 2; s++) begin : g_out
    assign bus.out_src_valid[s]             = w_woke[s][w_head_addr].valid;
    assign bus.out_src[s*DATA_W +: DATA_W]  = w_woke[s][w_head_addr].content;
  end

  assign bus.out_en      = w_out_en;
  assign bus.out_payload = w_pl_arr[w_head_addr];
  assign bus.in_reject   = w_full;
  assign bus.count       = r_count;

  a_unit_range : assert property (@(posedge clock) disable iff (reset)
    w_enq |-> ({1'b0, bus.in_unit} < (UNIT_W + 1)'(NUM_UNITS)));

endmodule
`default_nettype wire

// File: tb/tb_dispatch_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dispatch_buffer: directed scenarios for the dispatch queue. Rev 1.0
// ---------------------------------------------------------------------------
module tb_dispatch_buffer;
  import dispatch_buffer_pkg::*;

  localparam int DEPTH     = 4;
  localparam int NUM_UNITS = 5;
  localparam int NUM_WB    = 2;
  localparam int DATA_W    = 32;
  localparam int TAG_W     = 16;
  localparam int PAYLOAD_W = 64;
  localparam int UNIT_W    = 3;

  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  dispatch_buffer_if #(
    .DEPTH(DEPTH), .NUM_UNITS(NUM_UNITS), .NUM_WB(NUM_WB), .DATA_W(DATA_W),
    .TAG_W(TAG_W), .PAYLOAD_W(PAYLOAD_W), .UNIT_W(UNIT_W)
  ) bus ();

  dispatch_buffer #(
    .DEPTH(DEPTH), .NUM_UNITS(NUM_UNITS), .NUM_WB(NUM_WB), .DATA_W(DATA_W),
    .TAG_W(TAG_W), .PAYLOAD_W(PAYLOAD_W), .UNIT_W(UNIT_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.flash        = 1'b0;
    bus.in_en        = 1'b0;
    bus.in_unit      = '0;
    bus.in_payload   = '0;
    bus.in_src_valid = '0;
    bus.in_src       = '0;
    bus.wb_en        = '0;
    bus.wb_tag       = '0;
    bus.wb_data      = '0;
  endtask

  task automatic push(input logic [UNIT_W-1:0] unit, input logic [63:0] pl,
                      input logic [1:0] sv, input logic [31:0] s1, input logic [31:0] s2);
    bus.in_en        = 1'b1;
    bus.in_unit      = unit;
    bus.in_payload   = pl;
    bus.in_src_valid = sv;
    bus.in_src       = {s2, s1};
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    bus.out_reject = '1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    checks++; if (bus.in_reject !== 1'b0) begin failures++; $display("FAIL reset_in_reject got=%b exp=0", bus.in_reject); end
    checks++; if (bus.out_en !== 5'b0) begin failures++; $display("FAIL reset_out_en got=%b exp=00000", bus.out_en); end
    for (int k = 0; k < 3; k++) begin
      push(UNIT_W'(UNIT_ALU), 64'(k + 1), 2'b11, 32'h0, 32'h0);
      tick();
    end
    idle();
    checks++; if (bus.count !== 3'd3) begin failures++; $display("FAIL prefill_count got=%0d exp=3", bus.count); end
    checks++; if (bus.out_en !== 5'b00001) begin failures++; $display("FAIL prefill_out_en got=%b exp=00001", bus.out_en); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL async_reset_count got=%0d exp=0", bus.count); end
    checks++; if (bus.out_en !== 5'b0) begin failures++; $display("FAIL async_reset_out_en got=%b exp=00000", bus.out_en); end
    checks++; if (bus.in_reject !== 1'b0) begin failures++; $display("FAIL async_reset_in_reject got=%b exp=0", bus.in_reject); end
    #1 reset = 1'b0;
    bus.out_reject = '0;
    push(UNIT_W'(UNIT_BRANCH), 64'h0123_4567_89AB_CDEF, 2'b11, 32'h1, 32'h2);
    #1;
    checks++; if (bus.out_en !== 5'b0) begin failures++; $display("FAIL no_fallthrough got=%b exp=00000", bus.out_en); end
    tick();
    idle();
    checks++; if (bus.out_en !== 5'b00100) begin failures++; $display("FAIL post_reset_issue got=%b exp=00100", bus.out_en); end
    checks++; if (bus.out_payload !== 64'h0123_4567_89AB_CDEF) begin failures++; $display("FAIL post_reset_payload got=%h exp=0123456789abcdef", bus.out_payload); end
    tick();
    checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL post_reset_drain got=%0d exp=0", bus.count); end
  endtask

  task automatic test_full_drain();
    bus.out_reject = 5'b00001;
    for (int k = 0; k < 4; k++) begin
      push(UNIT_W'(UNIT_ALU), 64'(k + 1), 2'b11, 32'h0, 32'h0);
      tick();
    end
    push(UNIT_W'(UNIT_ALU), 64'h99, 2'b11, 32'h0, 32'h0);
    checks++; if (bus.in_reject !== 1'b1) begin failures++; $display("FAIL full_in_reject got=%b exp=1", bus.in_reject); end
    checks++; if (bus.count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", bus.count); end
    checks++; if (bus.out_en !== 5'b00001) begin failures++; $display("FAIL full_out_en got=%b exp=00001", bus.out_en); end
    tick();
    idle();
    checks++; if (bus.count !== 3'd4) begin failures++; $display("FAIL full_push_dropped got=%0d exp=4", bus.count); end
    bus.out_reject = '0;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.out_en !== 5'b00001) begin failures++; $display("FAIL drain_out_en[%0d] got=%b exp=00001", k, bus.out_en); end
      checks++; if (bus.out_payload !== 64'(k + 1)) begin failures++; $display("FAIL drain_payload[%0d] got=%0h exp=%0h", k, bus.out_payload, k + 1); end
      checks++; if (bus.in_reject !== (k == 0)) begin failures++; $display("FAIL drain_in_reject[%0d] got=%b exp=%b", k, bus.in_reject, (k == 0)); end
      tick();
    end
    checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL drain_count got=%0d exp=0", bus.count); end
    checks++; if (bus.out_en !== 5'b0) begin failures++; $display("FAIL drain_idle got=%b exp=00000", bus.out_en); end
  endtask

  task automatic test_back_to_back();
    bus.out_reject = '0;
    push(UNIT_W'(UNIT_FPU), 64'hA, 2'b11, 32'h0, 32'h0);
    tick();
    push(UNIT_W'(UNIT_MEMORY), 64'hB, 2'b11, 32'h0, 32'h0);
    checks++; if (bus.out_en !== 5'b00010) begin failures++; $display("FAIL b2b_first_issue got=%b exp=00010", bus.out_en); end
    checks++; if (bus.out_payload !== 64'hA) begin failures++; $display("FAIL b2b_first_payload got=%0h exp=a", bus.out_payload); end
    tick();
    idle();
    checks++; if (bus.count !== 3'd1) begin failures++; $display("FAIL b2b_count got=%0d exp=1", bus.count); end
    checks++; if (bus.out_en !== 5'b01000) begin failures++; $display("FAIL b2b_second_issue got=%b exp=01000", bus.out_en); end
    checks++; if (bus.out_payload !== 64'hB) begin failures++; $display("FAIL b2b_second_payload got=%0h exp=b", bus.out_payload); end
    tick();
    checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL b2b_drain got=%0d exp=0", bus.count); end
  endtask

  task automatic test_wakeup_stall();
    bus.out_reject = 5'b01000;
    push(UNIT_W'(UNIT_MEMORY), 64'h5, 2'b10, 32'h0000_0012, 32'h1111_1111);
    tick();
    idle();
    checks++; if (bus.out_src_valid !== 2'b10) begin failures++; $display("FAIL stall_pending got=%b exp=10", bus.out_src_valid); end
    checks++; if (bus.out_src[31:0] !== 32'h12) begin failures++; $display("FAIL stall_tag got=%h exp=00000012", bus.out_src[31:0]); end
    bus.wb_en   = 2'b10;
    bus.wb_tag  = {16'h0012, 16'h0000};
    bus.wb_data = {32'hDEAD_BEEF, 32'h0};
    #1;
    checks++; if (bus.out_src_valid !== 2'b11) begin failures++; $display("FAIL stall_bypass_valid got=%b exp=11", bus.out_src_valid); end
    tick();
    idle();
    checks++; if (bus.out_src_valid !== 2'b11) begin failures++; $display("FAIL stall_woken_valid got=%b exp=11", bus.out_src_valid); end
    checks++; if (bus.out_src[31:0] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL stall_woken_data got=%h exp=deadbeef", bus.out_src[31:0]); end
    checks++; if (bus.count !== 3'd1) begin failures++; $display("FAIL stall_held got=%0d exp=1", bus.count); end
    bus.wb_en   = 2'b01;
    bus.wb_tag  = {16'h0000, 16'h1111};
    bus.wb_data = {32'h0, 32'h2222_2222};
    #1;
    checks++; if (bus.out_src[63:32] !== 32'h1111_1111) begin failures++; $display("FAIL valid_not_overwritten got=%h exp=11111111", bus.out_src[63:32]); end
    bus.out_reject = '0;
    tick();
    idle();
    checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL stall_release got=%0d exp=0", bus.count); end
  endtask

  task automatic test_bypass_issue();
    bus.out_reject = '0;
    push(UNIT_W'(UNIT_FPU), 64'h77, 2'b01, 32'h0000_000A, 32'h0000_0005);
    tick();
    idle();
    bus.wb_en   = 2'b01;
    bus.wb_tag  = {16'h0000, 16'h0005};
    bus.wb_data = {32'h0, 32'hCAFE_F00D};
    #1;
    checks++; if (bus.out_en !== 5'b00010) begin failures++; $display("FAIL bypass_out_en got=%b exp=00010", bus.out_en); end
    checks++; if (bus.out_src_valid !== 2'b11) begin failures++; $display("FAIL bypass_valid got=%b exp=11", bus.out_src_valid); end
    checks++; if (bus.out_src !== {32'hCAFE_F00D, 32'h0000_000A}) begin failures++; $display("FAIL bypass_data got=%h exp=cafef00d0000000a", bus.out_src); end
    tick();
    idle();
    checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL bypass_dequeued got=%0d exp=0", bus.count); end
  endtask

  task automatic test_wb_priority();
    bus.out_reject = 5'b00001;
    push(UNIT_W'(UNIT_ALU), 64'h3, 2'b00, 32'h0000_0007, 32'h0000_0009);
    bus.wb_en   = 2'b11;
    bus.wb_tag  = {16'h0007, 16'h0007};
    bus.wb_data = {32'h2, 32'h1};
    tick();
    idle();
    checks++; if (bus.out_src_valid !== 2'b01) begin failures++; $display("FAIL prio_input_valid got=%b exp=01", bus.out_src_valid); end
    checks++; if (bus.out_src[31:0] !== 32'h1) begin failures++; $display("FAIL prio_input_data got=%h exp=00000001", bus.out_src[31:0]); end
    bus.wb_en   = 2'b11;
    bus.wb_tag  = {16'h0009, 16'h0009};
    bus.wb_data = {32'h4, 32'h3};
    #1;
    checks++; if (bus.out_src[63:32] !== 32'h3) begin failures++; $display("FAIL prio_bypass_data got=%h exp=00000003", bus.out_src[63:32]); end
    tick();
    idle();
    checks++; if (bus.out_src[63:32] !== 32'h3) begin failures++; $display("FAIL prio_stored_data got=%h exp=00000003", bus.out_src[63:32]); end
    bus.out_reject = '0;
    tick();
    checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL prio_drain got=%0d exp=0", bus.count); end
  endtask

  task automatic test_flash();
    bus.out_reject = '1;
    for (int k = 0; k < 3; k++) begin
      push(UNIT_W'(UNIT_BRANCH), 64'(k + 16), 2'b11, 32'h0, 32'h0);
      tick();
    end
    push(UNIT_W'(UNIT_UART), 64'h55, 2'b11, 32'h0, 32'h0);
    bus.flash = 1'b1;
    #1;
    checks++; if (bus.out_en !== 5'b0) begin failures++; $display("FAIL flash_out_en got=%b exp=00000", bus.out_en); end
    checks++; if (bus.count !== 3'd3) begin failures++; $display("FAIL flash_pre_count got=%0d exp=3", bus.count); end
    tick();
    idle();
    checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL flash_count got=%0d exp=0", bus.count); end
    checks++; if (bus.out_en !== 5'b0) begin failures++; $display("FAIL flash_no_issue got=%b exp=00000", bus.out_en); end
    checks++; if (bus.in_reject !== 1'b0) begin failures++; $display("FAIL flash_in_reject got=%b exp=0", bus.in_reject); end
    bus.out_reject = '0;
    tick();
    checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL flash_input_dropped got=%0d exp=0", bus.count); end
    checks++; if (bus.out_en !== 5'b0) begin failures++; $display("FAIL flash_still_empty got=%b exp=00000", bus.out_en); end
  endtask

  initial begin
    test_reset();
    test_full_drain();
    test_back_to_back();
    test_wakeup_stall();
    test_bypass_issue();
    test_wb_priority();
    test_flash();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dispatch_buffer.md
Name: dispatch_buffer

Overview:
- Parametrised in-order dispatch stage between instruction decode and the reservation stations.
- Holds up to DEPTH decoded instructions in a circular queue. Each entry carries a target-unit index, an opaque decoded payload, and two source operands.
- Every cycle, snoops NUM_WB completion buses and wakes up pending operands, both in the queue and on the input.
- Issues the head entry to its unit channel; a reject from that unit stalls the queue.

Parameters:
DEPTH, 4, queue entries; power of two, >= 2
NUM_UNITS, 5, number of issue channels (alu, fpu, branch, memory, uart)
NUM_WB, 2, number of completion/write-back buses snooped
DATA_W, 32, operand data width
TAG_W, 16, physical tag width; tag sits in content[TAG_W-1:0] while operand invalid
PAYLOAD_W, 64, opaque decoded-instruction width
UNIT_W, $clog2(NUM_UNITS), unit index width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
flash  in  1  synchronous pipeline flush (misprediction)
in_en  in  1  decode presents an instruction
in_reject  out  1  queue full; decode must hold
in_unit  in  UNIT_W  target unit index
in_payload  in  PAYLOAD_W  decoded fields
in_src_valid  in  2  operand valid bits [0]=src1 [1]=src2
in_src  in  2*DATA_W  operand data or tag
wb_en  in  NUM_WB  completion bus valid
wb_tag  in  NUM_WB*TAG_W  completed physical tag
wb_data  in  NUM_WB*DATA_W  completed value
out_en  out  NUM_UNITS  one-hot issue strobe
out_reject  in  NUM_UNITS  per-unit reservation station full
out_payload  out  PAYLOAD_W  head payload (shared by all channels)
out_src_valid  out  2  head operand valid after bypass
out_src  out  2*DATA_W  head operand data/tag after bypass
count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (async, any time): head = tail = 0, all entry valid bits cleared, count = 0, out_en = 0, in_reject = 0. Takes effect immediately, mid-operation included.
- Pointers: $clog2(DEPTH)+1 bits, MSB is the wrap bit.
  - full = addresses equal and wrap bits differ.
  - empty = pointers equal.
- in_reject = full. It comes from registered state only, with no same-cycle dequeue credit.
- Enqueue: occurs when in_en & ~in_reject & ~flash. Writes at tail; tail increments on the clock edge.
  - Incoming operands are woken against the current wb buses before being written.
- Issue (combinational from head):
  - if ~empty & ~flash, then out_en[head.unit] = 1 and all other bits are 0.
  - out_src equals the stored operand with same-cycle wb bypass applied.
- Dequeue: occurs when the issued channel has out_reject = 0. Head increments on the clock edge.
  - If rejected, the entry stays and the wakeup result is still written back.
  - Operands therefore never miss a completion while stalled.
- Latency: minimum 1 cycle, enqueue edge to out_en. There is no empty-queue fall-through.
- Throughput: 1 instruction/cycle. On a full queue the decode stage sees one bubble after a dequeue, because in_reject lags by 1 cycle.
- Wakeup, for each operand with valid = 0 (stored entries and input):
  - if any wb_en[i] & (wb_tag[i] == content[TAG_W-1:0]), then valid <= 1 and data <= wb_data[i].
  - If several buses match, the lowest index wins.
  - Operands that are already valid are never overwritten.
- Simultaneous enqueue and dequeue: both occur; count is unchanged.
- Enqueue and dequeue with count == 1: legal; the new entry becomes head next cycle.
- Flash: has priority over everything. During the flash cycle, out_en = 0 and enqueue is suppressed. On the edge, head = tail = 0 and count = 0; in_reject is 0 the next cycle.
- in_unit >= NUM_UNITS: the entry is dropped at the head without issuing (dequeued, out_en = 0). An assertion flags this in simulation.
- count updates on the clock edge: +1 on enqueue, -1 on dequeue.

Decomposition:
- Shared typedefs header:
  - DispatchEntry struct {unit, payload, Source src[2]}.
  - Parametrised Source {valid, content}.
  - UNIT_ALU..UNIT_UART index constants.
- Sub-module operand_wakeup: combinational; one operand plus NUM_WB buses in, woken operand out.
- operand_wakeup instances:
  - 2*DEPTH for the stored entries.
  - 2 for the input.
  - Head bypass is taken from the stored-entry instances, so no extra instances are needed.

Test Plan:
- Reset mid-traffic: fill 3 entries, assert reset -> count=0, out_en=0, in_reject=0 immediately; first post-reset enqueue issues after 1 cycle.
- Fill to DEPTH=4 with unit=0 and out_reject[0]=1 -> in_reject=1, count=4. Release reject -> 4 issues on consecutive cycles. in_reject falls 1 cycle after the first dequeue.
- Entry src1 tag 0x0012 invalid; wb_en[1]=1, wb_tag=0x0012, wb_data=0xDEADBEEF while the entry is stalled -> next cycle out_src_valid[0]=1, data 0xDEADBEEF.
- Head waiting on tag 0x0005; wb on the same cycle as issue -> out_src bypassed to the wb data on that cycle; the entry is dequeued.
- Two wb buses both hit tag 0x0007 with data 1 and 2 -> operand takes 1 (lowest index).
- Queue with 3 entries, flash together with in_en=1 -> out_en=0 that cycle; next cycle count=0, no issue; the input instruction is not stored.
